// File: rtl/ising_job_ctrl.sv
// Job sequencer upstream of ising_axi: programs counters, clears and loads weights,
// runs the array for a fixed time, then reads every spin phase back into a vector.
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | waiting for start
// S_CFG_CUT | counter cutoff write on the bus
// S_CFG_MAX | counter max write on the bus
// S_CLEAR   | walking the weight table with the uncoupled code
// S_EDGE    | accepting sparse edges, one write per handshake
// S_GO      | last edge done; START write issued on exit
// S_RUN     | anneal down-counter running
// S_READ    | reading phases, RD_LAT+1 cycles per spin
// S_FIN     | done pulse, back to idle
module ising_job_ctrl #(
    parameter int                     N                = 6,
    parameter int                     NUM_WEIGHTS      = 3,
    parameter logic [NUM_WEIGHTS-1:0] ZERO_WEIGHT      = NUM_WEIGHTS'(2),
    parameter int                     RD_LAT           = 1,
    parameter int                     IW               = $clog2(N),
    parameter logic [31:0]            CTR_CUTOFF_ADDR  = 32'h0000_0010,
    parameter logic [31:0]            CTR_MAX_ADDR     = 32'h0000_0020,
    parameter logic [31:0]            START_ADDR       = 32'h0000_0030,
    parameter logic [31:0]            WEIGHT_ADDR_BASE = 32'h0000_1000,
    parameter logic [31:0]            PHASE_ADDR_BASE  = 32'h0000_2000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            ctr_cutoff,
    input  logic [31:0]            ctr_max,
    input  logic [31:0]            run_cycles,
    input  logic                   edge_valid,
    output logic                   edge_ready,
    input  logic [IW-1:0]          edge_i,
    input  logic [IW-1:0]          edge_j,
    input  logic [NUM_WEIGHTS-1:0] edge_w,
    input  logic                   edge_last,
    output logic                   wr_valid,
    output logic [31:0]            wr_addr,
    output logic [31:0]            wdata,
    output logic [31:0]            araddr,
    input  logic [31:0]            rdata,
    output logic                   busy,
    output logic                   done,
    output logic [N-1:0]           phases,
    output logic                   err
);
    localparam int P    = N * (N - 1) / 2;
    localparam int IDXW = $clog2(P) + 1;
    localparam int RW   = $clog2(RD_LAT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG_CUT, S_CFG_MAX, S_CLEAR, S_EDGE, S_GO, S_RUN, S_READ, S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  clr_q, clr_d;
    logic [31:0]      max_q, max_d, run_q, run_d, cnt_q, cnt_d;
    logic [IW-1:0]    k_q, k_d;
    logic [RW-1:0]    sub_q, sub_d;
    logic             wr_valid_d, busy_d, done_d, err_d;
    logic [31:0]      wr_addr_d, wdata_d, araddr_d;
    logic [N-1:0]     phases_d;
    logic [IDXW-1:0]  row_base, edge_idx;
    logic             edge_legal, edge_hs;
    logic             rdata_unused;

    function automatic logic [31:0] weight_addr(input logic [IDXW-1:0] idx);
        return WEIGHT_ADDR_BASE + (32'(idx) << 5);
    endfunction

    function automatic logic [31:0] phase_addr(input logic [IW-1:0] k);
        return PHASE_ADDR_BASE + (32'(k) << 5);
    endfunction

    assign rdata_unused = ^rdata[31:1];
    assign edge_ready   = (state_q == S_EDGE);
    assign edge_hs      = edge_valid && edge_ready;
    assign edge_legal   = (edge_i < edge_j) && (32'(edge_j) < 32'(N));

    // Row base = sum of the row lengths above row i; avoids a multiplier.
    always_comb begin
        row_base = '0;
        for (int r = 0; r < N - 1; r++)
            if (IW'(r) < edge_i) row_base = row_base + IDXW'(N - 1 - r);
    end
    assign edge_idx = row_base + IDXW'(edge_j) - IDXW'(edge_i) - IDXW'(1);

    always_comb begin
        state_d    = state_q;
        clr_d      = clr_q;
        max_d      = max_q;
        run_d      = run_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        sub_d      = sub_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr;
        wdata_d    = wdata;
        araddr_d   = araddr;
        busy_d     = busy;
        done_d     = 1'b0;
        err_d      = err;
        phases_d   = phases;
        case (state_q)
            S_IDLE: if (start) begin
                max_d      = ctr_max;
                run_d      = run_cycles;
                err_d      = 1'b0;
                phases_d   = '0;
                busy_d     = 1'b1;
                wr_valid_d = 1'b1;
                wr_addr_d  = CTR_CUTOFF_ADDR;
                wdata_d    = ctr_cutoff;
                state_d    = S_CFG_CUT;
            end
            S_CFG_CUT: begin
                wr_valid_d = 1'b1;
                wr_addr_d  = CTR_MAX_ADDR;
                wdata_d    = max_q;
                state_d    = S_CFG_MAX;
            end
            S_CFG_MAX: begin
                clr_d      = '0;
                wr_valid_d = 1'b1;
                wr_addr_d  = weight_addr('0);
                wdata_d    = 32'(ZERO_WEIGHT);
                state_d    = S_CLEAR;
            end
            S_CLEAR: begin
                if (clr_q == IDXW'(P - 1)) begin
                    state_d = S_EDGE;
                end else begin
                    clr_d      = clr_q + IDXW'(1);
                    wr_valid_d = 1'b1;
                    wr_addr_d  = weight_addr(clr_q + IDXW'(1));
                    wdata_d    = 32'(ZERO_WEIGHT);
                end
            end
            S_EDGE: if (edge_hs) begin
                if (edge_legal) begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = weight_addr(edge_idx);
                    wdata_d    = 32'(edge_w);
                end else begin
                    err_d = 1'b1;
                end
                if (edge_last) state_d = S_GO;
            end
            S_GO: begin
                wr_valid_d = 1'b1;
                wr_addr_d  = START_ADDR;
                wdata_d    = 32'd1;
                if (run_q == 32'd0) begin
                    araddr_d = phase_addr('0);
                    k_d      = '0;
                    sub_d    = RW'(RD_LAT);
                    state_d  = S_READ;
                end else begin
                    cnt_d   = run_q - 32'd1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == 32'd0) begin
                    araddr_d = phase_addr('0);
                    k_d      = '0;
                    sub_d    = RW'(RD_LAT);
                    state_d  = S_READ;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_READ: begin
                if (sub_q == '0) begin
                    phases_d[k_q] = rdata[0];
                    if (k_q == IW'(N - 1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FIN;
                    end else begin
                        k_d      = k_q + IW'(1);
                        araddr_d = phase_addr(k_q + IW'(1));
                        sub_d    = RW'(RD_LAT);
                    end
                end else begin
                    sub_d = sub_q - RW'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            clr_q    <= '0;
            max_q    <= '0;
            run_q    <= '0;
            cnt_q    <= '0;
            k_q      <= '0;
            sub_q    <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wdata    <= '0;
            araddr   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            phases   <= '0;
        end else begin
            state_q  <= state_d;
            clr_q    <= clr_d;
            max_q    <= max_d;
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            sub_q    <= sub_d;
            wr_valid <= wr_valid_d;
            wr_addr  <= wr_addr_d;
            wdata    <= wdata_d;
            araddr   <= araddr_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            phases   <= phases_d;
        end
    end
endmodule

// File: tb/tb_ising_job_ctrl.sv
// Bench for ising_job_ctrl: behavioural ising_axi model (write log + delayed phase reads)
// and a pair-enumeration weight model, checked with immediate assertions.
module tb_ising_job_ctrl;
    localparam int N      = 6;
    localparam int NW     = 3;
    localparam int RD_LAT = 3;
    localparam int IW     = $clog2(N);
    localparam int P      = N * (N - 1) / 2;
    localparam logic [31:0] CUT_A = 32'h0000_0010;
    localparam logic [31:0] MAX_A = 32'h0000_0020;
    localparam logic [31:0] STA_A = 32'h0000_0030;
    localparam logic [31:0] WBASE = 32'h0000_1000;
    localparam logic [31:0] PBASE = 32'h0000_2000;
    localparam logic [NW-1:0] ZW  = 3'b010;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0]   ctr_cutoff = '0, ctr_max = '0, run_cycles = '0;
    logic          edge_valid = 1'b0, edge_ready, edge_last = 1'b0;
    logic [IW-1:0] edge_i = '0, edge_j = '0;
    logic [NW-1:0] edge_w = '0;
    logic          wr_valid, busy, done, err;
    logic [31:0]   wr_addr, wdata, araddr, rdata;
    logic [N-1:0]  phases;

    ising_job_ctrl #(
        .N(N), .NUM_WEIGHTS(NW), .ZERO_WEIGHT(ZW), .RD_LAT(RD_LAT), .IW(IW),
        .CTR_CUTOFF_ADDR(CUT_A), .CTR_MAX_ADDR(MAX_A), .START_ADDR(STA_A),
        .WEIGHT_ADDR_BASE(WBASE), .PHASE_ADDR_BASE(PBASE)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .ctr_cutoff(ctr_cutoff), .ctr_max(ctr_max),
        .run_cycles(run_cycles), .edge_valid(edge_valid), .edge_ready(edge_ready),
        .edge_i(edge_i), .edge_j(edge_j), .edge_w(edge_w), .edge_last(edge_last),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wdata(wdata), .araddr(araddr),
        .rdata(rdata), .busy(busy), .done(done), .phases(phases), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ising_axi read side: araddr seen RD_LAT cycles late, bit 0 from a preset pattern
    logic [31:0]  apipe [RD_LAT];
    logic [N-1:0] phase_pat = '0;
    always @(posedge clk) begin
        apipe[0] <= araddr;
        for (int i = 1; i < RD_LAT; i++) apipe[i] <= apipe[i-1];
    end
    always_comb begin
        rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < N; k++)
            if (apipe[RD_LAT-1] == PBASE + 32'(32 * k)) rdata = {31'h2AAA_AAAA, phase_pat[k]};
    end

    typedef struct { int c; logic [31:0] a; logic [31:0] d; } wr_t;
    function automatic wr_t mk(input int c, input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.c = c; w.a = a; w.d = d;
        return w;
    endfunction

    wr_t wq[$];
    wr_t exp_q[$];
    int  ndone = 0;
    always @(negedge clk) begin
        if (wr_valid) wq.push_back(mk(cyc, wr_addr, wdata));
        if (done) ndone++;
    end

    int errors = 0, checks = 0;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pair_idx(input int i, input int j);
        int n = 0;
        for (int a = 0; a < N; a++)
            for (int b = a + 1; b < N; b++) begin
                if (a == i && b == j) return n;
                n++;
            end
        return -1;
    endfunction

    int            qi[$], qj[$], qw[$];
    logic [NW-1:0] exp_w [P];
    logic [NW-1:0] act_w [P];
    int            s_cyc, hs_last, cur_rc;
    bit            any_illegal;
    int            mc_one[6]  = '{0, 3, 5, 6, 9, 12};
    int            mc_four[4] = '{4, 8, 11, 13};

    task automatic add_edge(input int i, input int j, input int w);
        qi.push_back(i); qj.push_back(j); qw.push_back(w);
    endtask

    task automatic start_job(input logic [31:0] cut, input logic [31:0] mx, input logic [31:0] rc);
        int n;
        wq.delete(); exp_q.delete(); ndone = 0; cur_rc = int'(rc); any_illegal = 0;
        for (int k = 0; k < P; k++) exp_w[k] = ZW;
        @(negedge clk);
        ctr_cutoff = cut; ctr_max = mx; run_cycles = rc; start = 1'b1;
        s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        ctr_cutoff = $urandom; ctr_max = $urandom; run_cycles = $urandom;
        check("err_cleared_on_start", err, 0);
        check("busy_on_start", busy, 1);
        check("phases_cleared_on_start", phases, 0);
        exp_q.push_back(mk(s_cyc + 1, CUT_A, cut));
        exp_q.push_back(mk(s_cyc + 2, MAX_A, mx));
        for (int k = 0; k < P; k++) exp_q.push_back(mk(s_cyc + 3 + k, WBASE + 32'(32 * k), 32'(ZW)));
        n = 0;
        while (!edge_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("edge_entry_cycle", cyc, s_cyc + 3 + P);
    endtask

    task automatic send_edges(input int gap_pct, input bit mid_start);
        bit legal;
        for (int e = 0; e < qi.size(); e++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) @(negedge clk);
            if (mid_start && e == 1) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            edge_valid = 1'b1;
            edge_i = IW'(qi[e]); edge_j = IW'(qj[e]); edge_w = NW'(qw[e]);
            edge_last = (e == qi.size() - 1);
            check("edge_ready_in_edge", edge_ready, 1);
            legal = (qi[e] < qj[e]) && (qj[e] < N);
            if (legal) begin
                exp_q.push_back(mk(cyc + 1, WBASE + 32'(32 * pair_idx(qi[e], qj[e])), 32'(qw[e])));
                exp_w[pair_idx(qi[e], qj[e])] = NW'(qw[e]);
            end else begin
                any_illegal = 1;
            end
            hs_last = cyc;
            @(negedge clk);
            edge_valid = 1'b0; edge_last = 1'b0;
            if (!legal) check("err_after_illegal", err, 1);
        end
        exp_q.push_back(mk(hs_last + 2, STA_A, 32'd1));
    endtask

    task automatic finish_job();
        int n = 0, rs = -1;
        int limit = cur_rc + N * (RD_LAT + 1) + 50;
        while (!done && n < limit) begin
            if (rs < 0 && araddr == PBASE) rs = cyc;
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
        check("read_start_cycle", rs, hs_last + 2 + cur_rc);
        check("read_length", cyc - rs, N * (RD_LAT + 1));
        check("busy_at_done", busy, 0);
        check("phases", phases, phase_pat);
        check("err_at_done", err, any_illegal);
        @(negedge clk);
        check("done_single_cycle", done, 0);
        check("phases_hold", phases, phase_pat);
        check("done_count", ndone, 1);
        check("write_count", wq.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < wq.size(); k++) begin
            check("write_cycle", wq[k].c, exp_q[k].c);
            check("write_addr", wq[k].a, exp_q[k].a);
            check("write_data", wq[k].d, exp_q[k].d);
        end
        for (int k = 0; k < P; k++) act_w[k] = 'x;
        foreach (wq[k])
            if (wq[k].a >= WBASE && wq[k].a < WBASE + 32'(32 * P))
                act_w[(wq[k].a - WBASE) >> 5] = wq[k].d[NW-1:0];
        for (int k = 0; k < P; k++) check("weight_table", act_w[k], exp_w[k]);
    endtask

    task automatic check_reset_outputs();
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_araddr", araddr, 0);
        check("rst_edge_ready", edge_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_phases", phases, 0);
        check("rst_err", err, 0);
    endtask

    initial begin
        int nw, i, j;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // max-cut job with the reference edge list
        phase_pat = 6'b101101;
        qi.delete(); qj.delete(); qw.delete();
        add_edge(0, 1, 1); add_edge(0, 4, 1); add_edge(1, 2, 1);
        add_edge(1, 3, 1); add_edge(2, 3, 1); add_edge(3, 4, 1);
        add_edge(0, 5, 4); add_edge(1, 5, 4); add_edge(2, 5, 4); add_edge(3, 5, 4);
        start_job(32'h4000, 32'h8000, 500);
        send_edges(0, 0);
        finish_job();
        foreach (mc_one[k])  check("maxcut_w001", act_w[mc_one[k]], 3'b001);
        foreach (mc_four[k]) check("maxcut_w100", act_w[mc_four[k]], 3'b100);

        // illegal edges only; START must still go out
        qi.delete(); qj.delete(); qw.delete();
        add_edge(3, 2, 5); add_edge(1, 6, 7);
        start_job(32'h1, 32'h2, 7);
        send_edges(0, 0);
        finish_job();

        // random edges with gaps, including a duplicate pair
        phase_pat = 6'b010110;
        qi.delete(); qj.delete(); qw.delete();
        for (int e = 0; e < 10; e++) begin
            if ($urandom_range(0, 9) < 8) begin
                i = int'($urandom_range(0, N - 2));
                j = int'($urandom_range(i + 1, N - 1));
            end else begin
                i = int'($urandom_range(0, 7));
                j = int'($urandom_range(0, 7));
            end
            add_edge(i, j, int'($urandom_range(0, 7)));
        end
        add_edge(qi[0], qj[0], int'($urandom_range(0, 7)));
        add_edge(1, 4, int'($urandom_range(0, 7)));
        start_job($urandom, $urandom, $urandom_range(1, 30));
        send_edges(50, 0);
        finish_job();

        // zero run time and a start pulse while busy
        phase_pat = 6'b110011;
        qi.delete(); qj.delete(); qw.delete();
        add_edge(0, 1, 3); add_edge(2, 4, 6); add_edge(4, 5, 0);
        start_job(32'hAAAA_0001, 32'h5555_0002, 0);
        send_edges(0, 1);
        finish_job();

        // reset in the middle of RUN, then a clean job
        qi.delete(); qj.delete(); qw.delete();
        add_edge(1, 2, 1); add_edge(3, 4, 2);
        start_job(32'h5, 32'h6, 500);
        send_edges(0, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        nw = wq.size();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("no_writes_after_reset", wq.size(), nw);
        phase_pat = 6'b011001;
        qi.delete(); qj.delete(); qw.delete();
        add_edge(0, 2, 7); add_edge(2, 5, 1); add_edge(0, 2, 3);
        start_job(32'h77, 32'h88, 20);
        send_edges(30, 0);
        finish_job();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
